// File: rtl/jt6295_adpcm_enc_pkg.sv
// -----------------------------------------------------------------------------
// jt6295_pkg
// Shared constants and types for the JT6295 ADPCM encoder and its
// reconstruction model: OKI step table, index adjustment table, FSM state
// enum and width constants.
// -----------------------------------------------------------------------------
package jt6295_pkg;

    localparam int PCM_W   = 12;
    localparam int CODE_W  = 4;
    localparam int STEP_W  = 11;
    localparam int IDX_W   = 6;
    localparam int MAG_W   = PCM_W + 1;
    localparam int IDX_MAX = 48;

    typedef logic [STEP_W-1:0] step_t;

    // Standard OKI/Dialogic step table, 49 entries
    localparam step_t STEP_TABLE [0:IDX_MAX] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    // Index adjustment by code magnitude; +8 needs five bits signed
    localparam logic signed [4:0] ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_UPD
    } state_t;

    // Out-of-range indices never occur, but map them to the last entry
    function automatic step_t step_lookup(input logic [IDX_W-1:0] idx);
        step_lookup = (idx > IDX_W'(IDX_MAX)) ? STEP_TABLE[IDX_MAX] : STEP_TABLE[idx];
    endfunction

endpackage

// File: rtl/jt6295_adpcm_enc_model.sv
// -----------------------------------------------------------------------------
// jt6295_adpcm_model
// Combinational ADPCM reconstruction step: from the current code, step,
// predictor and step index it produces the next predictor (saturated) and
// the next step index (clamped to 0..48).
// Ports:
//   i_code  4-bit code {sign, b2, b1, b0}
//   i_step  current step size
//   i_pred  current predictor (signed)
//   i_idx   current step index
//   o_pred  next predictor
//   o_idx   next step index
//   o_clip  predictor sum was clamped (JT6295_ADPCM_ENC_CLIP_EN builds only)
// -----------------------------------------------------------------------------
module jt6295_adpcm_model
    import jt6295_pkg::*;
#(
    parameter int SAT_HI = 2047,
    parameter int SAT_LO = -2048
)(
    input  logic [CODE_W-1:0]       i_code,
    input  logic [STEP_W-1:0]       i_step,
    input  logic signed [PCM_W-1:0] i_pred,
    input  logic [IDX_W-1:0]        i_idx,
    output logic signed [PCM_W-1:0] o_pred,
    output logic [IDX_W-1:0]        o_idx
`ifdef JT6295_ADPCM_ENC_CLIP_EN
    ,
    output logic                    o_clip
`endif
);

    logic [MAG_W-1:0]         w_diff;
    logic signed [MAG_W+1:0]  w_sum;
    logic signed [IDX_W+1:0]  w_idx_sum;
    logic                     w_clip;

    always_comb begin
        w_diff = MAG_W'(i_step >> 3);
        if (i_code[2]) w_diff = w_diff + MAG_W'(i_step);
        if (i_code[1]) w_diff = w_diff + MAG_W'(i_step >> 1);
        if (i_code[0]) w_diff = w_diff + MAG_W'(i_step >> 2);

        if (i_code[3])
            w_sum = $signed({{3{i_pred[PCM_W-1]}}, i_pred}) - $signed({2'b00, w_diff});
        else
            w_sum = $signed({{3{i_pred[PCM_W-1]}}, i_pred}) + $signed({2'b00, w_diff});

        w_clip = 1'b0;
        if (w_sum > (MAG_W+2)'(SAT_HI)) begin
            o_pred = PCM_W'(SAT_HI);
            w_clip = 1'b1;
        end else if (w_sum < (MAG_W+2)'(SAT_LO)) begin
            o_pred = PCM_W'(SAT_LO);
            w_clip = 1'b1;
        end else begin
            o_pred = w_sum[PCM_W-1:0];
        end

        w_idx_sum = $signed({2'b00, i_idx}) + (IDX_W+2)'(ADJ[i_code[2:0]]);
        if (w_idx_sum < 0)
            o_idx = '0;
        else if (w_idx_sum > (IDX_W+2)'(IDX_MAX))
            o_idx = IDX_W'(IDX_MAX);
        else
            o_idx = w_idx_sum[IDX_W-1:0];
    end

`ifdef JT6295_ADPCM_ENC_CLIP_EN
    assign o_clip = w_clip;
`endif

endmodule

// File: rtl/jt6295_adpcm_enc.sv
// -----------------------------------------------------------------------------
// jt6295_adpcm_enc
// OKI 4-bit ADPCM encoder producing codes the JT6295 decoder reproduces
// bit-exactly. The code is found by successive approximation, one bit per
// cen cycle, against the shared reconstruction model.
// Ports:
//   rst        async reset, active-high
//   clk        clock
//   cen        clock enable for the FSM
//   clr        sync predictor/index clear, aborts any in-flight sample
//   din        signed 12-bit PCM sample, qualified by din_valid
//   din_ready  encoder idle
//   code       ADPCM code {sign, magnitude[2:0]}
//   code_valid one-clk pulse on code update
//   pred       reconstructed sample
//   clip_cnt   saturating count of clamped updates (only with
//              JT6295_ADPCM_ENC_CLIP_EN defined)
// -----------------------------------------------------------------------------
module jt6295_adpcm_enc
    import jt6295_pkg::*;
#(
    parameter int SAT_HI = 2047,
    parameter int SAT_LO = -2048
)(
    input  logic                    rst,
    input  logic                    clk,
    input  logic                    cen,
    input  logic                    clr,
    input  logic signed [PCM_W-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [CODE_W-1:0]       code,
    output logic                    code_valid,
    output logic signed [PCM_W-1:0] pred
`ifdef JT6295_ADPCM_ENC_CLIP_EN
    ,
    output logic [7:0]              clip_cnt
`endif
);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic signed [MAG_W-1:0] r_delta;
    logic [MAG_W-1:0]        r_mag;
    logic                    r_sign;
    logic [2:0]              r_bits;

    step_t                   w_step;
    logic [MAG_W-1:0]        w_thr;
    logic                    w_ge;
    logic signed [PCM_W-1:0] w_pred_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
`ifdef JT6295_ADPCM_ENC_CLIP_EN
    logic                    w_clip;
`endif

    assign w_step = step_lookup(r_idx);

    // Threshold for the bit being resolved in the current state
    always_comb begin
        case (r_state)
            ST_B1:   w_thr = MAG_W'(w_step >> 1);
            ST_B0:   w_thr = MAG_W'(w_step >> 2);
            default: w_thr = MAG_W'(w_step);
        endcase
        w_ge = (r_mag >= w_thr);
    end

    jt6295_adpcm_model #(
        .SAT_HI (SAT_HI),
        .SAT_LO (SAT_LO)
    ) u_model (
        .i_code (CODE_W'({r_sign, r_bits})),
        .i_step (w_step),
        .i_pred (pred),
        .i_idx  (r_idx),
        .o_pred (w_pred_nxt),
        .o_idx  (w_idx_nxt)
`ifdef JT6295_ADPCM_ENC_CLIP_EN
        ,
        .o_clip (w_clip)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_delta    <= '0;
            r_mag      <= '0;
            r_sign     <= 1'b0;
            r_bits     <= '0;
            pred       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            din_ready  <= 1'b1;
`ifdef JT6295_ADPCM_ENC_CLIP_EN
            clip_cnt   <= '0;
`endif
        end else begin
            code_valid <= 1'b0;
            if (clr) begin
                r_state   <= ST_IDLE;
                r_idx     <= '0;
                pred      <= '0;
                din_ready <= 1'b1;
`ifdef JT6295_ADPCM_ENC_CLIP_EN
                clip_cnt  <= '0;
`endif
            end else if (cen) begin
                case (r_state)
                    ST_IDLE: begin
                        if (din_valid) begin
                            r_delta   <= $signed({din[PCM_W-1], din}) - $signed({pred[PCM_W-1], pred});
                            din_ready <= 1'b0;
                            r_state   <= ST_SIGN;
                        end
                    end
                    ST_SIGN: begin
                        r_sign  <= r_delta[MAG_W-1];
                        r_mag   <= r_delta[MAG_W-1] ? unsigned'(-r_delta) : unsigned'(r_delta);
                        r_bits  <= '0;
                        r_state <= ST_B2;
                    end
                    ST_B2: begin
                        if (w_ge) begin
                            r_bits[2] <= 1'b1;
                            r_mag     <= r_mag - w_thr;
                        end
                        r_state <= ST_B1;
                    end
                    ST_B1: begin
                        if (w_ge) begin
                            r_bits[1] <= 1'b1;
                            r_mag     <= r_mag - w_thr;
                        end
                        r_state <= ST_B0;
                    end
                    ST_B0: begin
                        if (w_ge) begin
                            r_bits[0] <= 1'b1;
                            r_mag     <= r_mag - w_thr;
                        end
                        r_state <= ST_UPD;
                    end
                    ST_UPD: begin
                        pred       <= w_pred_nxt;
                        r_idx      <= w_idx_nxt;
                        code       <= {r_sign, r_bits};
                        code_valid <= 1'b1;
                        din_ready  <= 1'b1;
                        r_state    <= ST_IDLE;
`ifdef JT6295_ADPCM_ENC_CLIP_EN
                        if (w_clip && (clip_cnt != 8'hFF))
                            clip_cnt <= clip_cnt + 8'd1;
`endif
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt6295_adpcm_enc.sv
// -----------------------------------------------------------------------------
// tb_jt6295_adpcm_enc
// Directed bench for jt6295_adpcm_enc: a table of hand-computed samples plus
// sequences for busy-ignore, reset/clr mid-sample, saturation and a throttled
// random stream checked against an independent encoder/decoder model.
// -----------------------------------------------------------------------------
module tb_jt6295_adpcm_enc;

    logic               rst, clk, cen, clr, din_valid;
    logic               din_ready, code_valid;
    logic signed [11:0] din, pred;
    logic [3:0]         code;
`ifdef JT6295_ADPCM_ENC_CLIP_EN
    logic [7:0]         clip_cnt;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    jt6295_adpcm_enc dut (
        .rst        (rst),
        .clk        (clk),
        .cen        (cen),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .code       (code),
        .code_valid (code_valid),
        .pred       (pred)
`ifdef JT6295_ADPCM_ENC_CLIP_EN
        ,
        .clip_cnt   (clip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int STEPS [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                       73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
                       253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724,
                       796, 876, 963, 1060, 1166, 1282, 1411, 1552};
    int m_pred = 0;
    int m_idx  = 0;

    function automatic logic [3:0] ref_encode(input int d);
        int delta, mag, st;
        logic [3:0] c;
        c     = '0;
        delta = d - m_pred;
        st    = STEPS[m_idx];
        c[3]  = (delta < 0);
        mag   = (delta < 0) ? -delta : delta;
        if (mag >= st)     begin c[2] = 1'b1; mag = mag - st;     end
        if (mag >= st / 2) begin c[1] = 1'b1; mag = mag - st / 2; end
        if (mag >= st / 4) c[0] = 1'b1;
        return c;
    endfunction

    task automatic ref_decode(input logic [3:0] c);
        int st, diff;
        st   = STEPS[m_idx];
        diff = st / 8;
        if (c[2]) diff = diff + st;
        if (c[1]) diff = diff + st / 2;
        if (c[0]) diff = diff + st / 4;
        m_pred = c[3] ? m_pred - diff : m_pred + diff;
        if (m_pred > 2047)  m_pred = 2047;
        if (m_pred < -2048) m_pred = -2048;
        case (c[2:0])
            3'd4:    m_idx = m_idx + 2;
            3'd5:    m_idx = m_idx + 4;
            3'd6:    m_idx = m_idx + 6;
            3'd7:    m_idx = m_idx + 8;
            default: m_idx = m_idx - 1;
        endcase
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        cen = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        cen = 1'b1;
        m_pred = 0;
        m_idx  = 0;
    endtask

    // Offer one sample with cen high one cycle in 'period'; returns the code,
    // predictor and number of cen edges between accept and code_valid.
    task automatic encode(input logic signed [11:0] d, input int unsigned period,
                          output logic [3:0] c, output logic signed [11:0] p,
                          output int unsigned lat, output bit tmo);
        bit acc, acc_now;
        int unsigned ncen;
        acc = 1'b0; ncen = 0; lat = 0; tmo = 1'b1; c = '0; p = '0;
        for (int unsigned k = 0; k < 400; k++) begin
            @(negedge clk);
            cen       = ((k % period) == 0);
            din       = d;
            din_valid = !acc;
            acc_now   = !acc && cen && din_ready;
            if (acc && cen) ncen++;
            @(posedge clk);
            #1;
            if (acc_now) acc = 1'b1;
            if (acc && code_valid) begin
                c = code; p = pred; lat = ncen; tmo = 1'b0;
                break;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        cen       = 1'b1;
    endtask

    typedef struct {
        bit                 clr_first;
        logic signed [11:0] din;
        logic [3:0]         code;
        logic signed [11:0] pred;
    } vec_t;

    vec_t               vecs [13];
    logic [3:0]         c, exp_c;
    logic signed [11:0] p, d, prev;
    int unsigned        lat, rdy_seen, cv_cnt, wrap;
    bit                 tmo, got;

    initial begin
        vecs[0]  = '{1'b1, 12'sd0,     4'b0000, 12'sd2};
        vecs[1]  = '{1'b1, 12'sd100,   4'b0111, 12'sd30};
        vecs[2]  = '{1'b0, 12'sd100,   4'b0111, 12'sd93};
        vecs[3]  = '{1'b0, 12'sd0,     4'b1101, -12'sd7};
        vecs[4]  = '{1'b0, -12'sd7,    4'b0000, 12'sd6};
        vecs[5]  = '{1'b1, -12'sd100,  4'b1111, -12'sd30};
        vecs[6]  = '{1'b0, -12'sd100,  4'b1111, -12'sd93};
        vecs[7]  = '{1'b1, 12'sd2047,  4'b0111, 12'sd30};
        vecs[8]  = '{1'b1, -12'sd2048, 4'b1111, -12'sd30};
        vecs[9]  = '{1'b1, 12'sd16,    4'b0100, 12'sd18};
        vecs[10] = '{1'b0, 12'sd18,    4'b0000, 12'sd20};
        vecs[11] = '{1'b0, 12'sd20,    4'b0000, 12'sd22};
        vecs[12] = '{1'b1, 12'sd15,    4'b0011, 12'sd14};

        rst = 1'b1; cen = 1'b0; clr = 1'b0; din = '0; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_code",       code,       0);
        check("rst_code_valid", code_valid, 0);
        check("rst_din_ready",  din_ready,  1);
        check("rst_pred",       pred,       0);
`ifdef JT6295_ADPCM_ENC_CLIP_EN
        check("rst_clip_cnt",   clip_cnt,   0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].clr_first) do_clr();
            encode(vecs[i].din, 1, c, p, lat, tmo);
            check($sformatf("vec%0d_timeout", i), tmo, 0);
            check($sformatf("vec%0d_code", i), c, vecs[i].code);
            check($sformatf("vec%0d_pred", i), p, vecs[i].pred);
            check($sformatf("vec%0d_latency", i), lat, 5);
        end

        // ---- async reset in the middle of a sample ----
        @(negedge clk); cen = 1'b1; din = 12'sd300; din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); din_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_pred",      pred,       0);
        check("midrst_code",      code,       0);
        check("midrst_din_ready", din_ready,  1);
        check("midrst_cv",        code_valid, 0);
        @(negedge clk); rst = 1'b0;
        m_pred = 0; m_idx = 0;
        cv_cnt = 0;
        repeat (8) begin @(posedge clk); #1; if (code_valid) cv_cnt++; end
        check("midrst_no_cv", cv_cnt, 0);

        // ---- din_valid held while busy is ignored ----
        @(negedge clk); cen = 1'b1; din = 12'sd100; din_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_accept_ready", din_ready, 0);
        rdy_seen = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            din = -12'sd500;
            if (din_ready) rdy_seen++;
            @(posedge clk); #1;
            if (code_valid) begin got = 1'b1; c = code; p = pred; break; end
        end
        @(negedge clk); din_valid = 1'b0;
        check("busy_got_code", got, 1);
        check("busy_ready_low", rdy_seen, 0);
        check("busy_code", c, 4'b0111);
        check("busy_pred", p, 30);
        @(posedge clk); #1;
        check("cv_pulse_width", code_valid, 0);
        check("ready_after", din_ready, 1);

        // ---- saturation at the upper clamp ----
        do_clr();
        prev = '0; wrap = 0;
        for (int i = 0; i < 40; i++) begin
            exp_c = ref_encode(2047);
            encode(12'sd2047, 1, c, p, lat, tmo);
            check($sformatf("sat%0d_code", i), c, exp_c);
            ref_decode(c);
            check($sformatf("sat%0d_pred", i), p, m_pred);
            if (p < prev) wrap++;
            prev = p;
        end
        check("sat_final_pred", p, 2047);
        check("sat_no_wrap", wrap, 0);
`ifdef JT6295_ADPCM_ENC_CLIP_EN
        check("sat_clip_nonzero", clip_cnt != 8'd0, 1);
`endif

        // ---- clr while resolving B1 ----
        @(negedge clk); cen = 1'b1; din = 12'sd500; din_valid = 1'b1;
        @(posedge clk); #1;
        check("clrb1_accept", din_ready, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); clr = 1'b1; cen = 1'b0;
        @(posedge clk); #1;
        check("clrb1_cv",    code_valid, 0);
        check("clrb1_pred",  pred,       0);
        check("clrb1_ready", din_ready,  1);
`ifdef JT6295_ADPCM_ENC_CLIP_EN
        check("clrb1_clip",  clip_cnt,   0);
`endif
        @(negedge clk); clr = 1'b0; din_valid = 1'b0; cen = 1'b1;
        m_pred = 0; m_idx = 0;
        cv_cnt = 0;
        repeat (8) begin @(posedge clk); #1; if (code_valid) cv_cnt++; end
        check("clrb1_no_cv", cv_cnt, 0);
        encode(12'sd0, 1, c, p, lat, tmo);
        check("clrb1_after_code", c, 4'b0000);
        check("clrb1_after_pred", p, 2);

        // ---- throttled random stream, closed loop through the decoder model ----
        do_clr();
        for (int i = 0; i < 30; i++) begin
            d     = 12'($urandom);
            exp_c = ref_encode(int'(d));
            encode(d, 4, c, p, lat, tmo);
            check($sformatf("rnd%0d_timeout", i), tmo, 0);
            check($sformatf("rnd%0d_code", i), c, exp_c);
            ref_decode(c);
            check($sformatf("rnd%0d_pred", i), p, m_pred);
            check($sformatf("rnd%0d_latency", i), lat, 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
